// File: rtl/prio_enc_seg_scan_if.sv
// Request/code/display bundle of the priority encoder with 7-segment scan.
// master = the side driving the request lines, slave = the encoder itself.
interface prio_enc_seg_scan_if #(
  parameter int IN_WIDTH = 16,
  parameter int CODE_W   = 4,
  parameter int DIGITS   = 2
);
  logic                EI;
  logic                HOLD;
  logic [IN_WIDTH-1:0] DataIn;
  logic [CODE_W-1:0]   Y;
  logic                GS;
  logic                EO;
  logic [7:0]          Seg;
  logic [DIGITS-1:0]   An;

  modport master (
    output EI, HOLD, DataIn,
    input  Y, GS, EO, Seg, An
  );

  modport slave (
    input  EI, HOLD, DataIn,
    output Y, GS, EO, Seg, An
  );
endinterface

// File: rtl/prio_enc_seg_scan.sv
// Registered priority encoder (highest index wins) with active-low cascade
// enable, optional hold of the last valid code, and a time-multiplexed
// decimal seven-segment driver showing the registered code.
module prio_enc_seg_scan #(
  parameter int IN_WIDTH       = 16,
  parameter int CODE_W         = 4,
  parameter int DIGITS         = 2,
  parameter int SCAN_DIV       = 1000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input logic               SYSCLK,
  input logic               SYSRESET,
  prio_enc_seg_scan_if.slave bus
);

  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam int DSEL_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // Polarity masks: XOR-ed onto the active-high drive as the very last step.
  localparam logic [7:0]        SEG_POL = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] AN_POL  = {DIGITS{(SEG_ACTIVE_LOW != 0)}};

  localparam logic [7:0] GLYPH_DASH = 8'h40;  // segment g only

  // Active-high {dp,g,f,e,d,c,b,a} pattern for one decimal digit.
  function automatic logic [7:0] glyph(input logic [3:0] v);
    case (v)
      4'd0:    glyph = 8'h3F;
      4'd1:    glyph = 8'h06;
      4'd2:    glyph = 8'h5B;
      4'd3:    glyph = 8'h4F;
      4'd4:    glyph = 8'h66;
      4'd5:    glyph = 8'h6D;
      4'd6:    glyph = 8'h7D;
      4'd7:    glyph = 8'h07;
      4'd8:    glyph = 8'h7F;
      4'd9:    glyph = 8'h6F;
      default: glyph = 8'h00;
    endcase
  endfunction

  logic              en;
  logic              any;
  logic [CODE_W-1:0] idx;
  logic [CODE_W-1:0] y_q;
  logic              gs_q;
  logic              eo_q;
  logic              hold_q;

  assign en  = ~bus.EI;
  assign any = |bus.DataIn;

  // Highest set request bit; later (higher) indices overwrite lower ones.
  always_comb begin
    // NOTE: default first so every path assigns idx and no latch is inferred.
    idx = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (bus.DataIn[i]) idx = CODE_W'(i);
    end
  end

  // Encode stage: Y/GS/EO registered, independent of the scan counters.
  always_ff @(posedge SYSCLK) begin
    // NOTE: non-blocking updates so every register samples pre-edge values.
    if (SYSRESET) begin
      y_q    <= '0;
      gs_q   <= 1'b0;
      eo_q   <= 1'b1;
      hold_q <= 1'b0;
    end else begin
      hold_q <= bus.HOLD;
      if (en && any) begin
        y_q  <= idx;
        gs_q <= 1'b1;
        eo_q <= 1'b1;
      end else begin
        gs_q <= 1'b0;
        eo_q <= ~en;  // 0 only when enabled with nothing requested
        if (!bus.HOLD) y_q <= '0;
      end
    end
  end

  assign bus.Y  = y_q;
  assign bus.GS = gs_q;
  assign bus.EO = eo_q;

  logic [3:0]        bcd   [DIGITS];
  logic [DIGITS-1:0] blank;
  logic              show;

  assign show = gs_q | hold_q;

  // Binary-to-BCD of the registered code, with leading-zero blanking above
  // digit 0 so a zero code still displays a single "0".
  always_comb begin
    int unsigned val;
    logic        lead;
    val = {{(32-CODE_W){1'b0}}, y_q};
    for (int d = 0; d < DIGITS; d++) begin
      bcd[d] = 4'(val % 10);
      val    = val / 10;
    end
    blank = '0;
    lead  = 1'b1;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      if (bcd[d] != 4'd0) lead = 1'b0;
      blank[d] = lead;
    end
  end

  logic [DIV_W-1:0]  div_q;
  logic [DSEL_W-1:0] dsel_q;
  logic [DSEL_W-1:0] dsel_nxt;
  logic              div_wrap;
  logic [7:0]        seg_nxt;
  logic [DIGITS-1:0] an_nxt;
  logic [7:0]        seg_q;
  logic [DIGITS-1:0] an_q;

  assign div_wrap = (div_q == DIV_W'(SCAN_DIV - 1));

  // Next lit digit and its glyph; An and Seg are loaded together from these.
  always_comb begin
    dsel_nxt = dsel_q;
    if (div_wrap) begin
      dsel_nxt = (dsel_q == DSEL_W'(DIGITS - 1)) ? '0 : dsel_q + DSEL_W'(1);
    end
    seg_nxt = 8'h00;
    an_nxt  = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (dsel_nxt == DSEL_W'(d)) begin
        an_nxt[d] = 1'b1;
        if (!show)         seg_nxt = GLYPH_DASH;
        else if (blank[d]) seg_nxt = 8'h00;
        else               seg_nxt = glyph(bcd[d]);
      end
    end
  end

  // Scan divider, digit select and registered display drive.
  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      div_q  <= '0;
      dsel_q <= '0;
      an_q   <= AN_POL ^ DIGITS'(1);
      seg_q  <= SEG_POL;
    end else begin
      div_q  <= div_wrap ? '0 : div_q + DIV_W'(1);
      dsel_q <= dsel_nxt;
      an_q   <= AN_POL ^ an_nxt;
      seg_q  <= SEG_POL ^ seg_nxt;
    end
  end

  assign bus.Seg = seg_q;
  assign bus.An  = an_q;

endmodule

// File: tb/tb_prio_enc_seg_scan.sv
// Directed bench: one 16-line/2-digit instance (SCAN_DIV=4, active-low
// display) plus two cascaded 8-line instances sharing clock and reset.
module tb_prio_enc_seg_scan;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;  // edges since reset release: div = cyc%4, dsel = (cyc/4)%2

  always #5 clk = ~clk;

  prio_enc_seg_scan_if #(.IN_WIDTH(16), .CODE_W(4), .DIGITS(2)) bus0 ();
  prio_enc_seg_scan_if #(.IN_WIDTH(8),  .CODE_W(3), .DIGITS(1)) bus_up ();
  prio_enc_seg_scan_if #(.IN_WIDTH(8),  .CODE_W(3), .DIGITS(1)) bus_lo ();

  assign bus_lo.EI = bus_up.EO;

  prio_enc_seg_scan #(
    .IN_WIDTH(16), .CODE_W(4), .DIGITS(2), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1)
  ) u_dut (.SYSCLK(clk), .SYSRESET(rst), .bus(bus0));

  prio_enc_seg_scan #(
    .IN_WIDTH(8), .CODE_W(3), .DIGITS(1), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1)
  ) u_up (.SYSCLK(clk), .SYSRESET(rst), .bus(bus_up));

  prio_enc_seg_scan #(
    .IN_WIDTH(8), .CODE_W(3), .DIGITS(1), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1)
  ) u_lo (.SYSCLK(clk), .SYSRESET(rst), .bus(bus_lo));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    if (rst) cyc = 0;
    else     cyc++;
    #1;
  endtask

  // Let new inputs settle through encode and display, then stop at the first
  // cycle of scan phase p (0..7 within the 8-cycle frame).
  task automatic goto_phase(input int p);
    tick();
    tick();
    for (int i = 0; i < 8 && (cyc % 8) != p; i++) tick();
  endtask

  function automatic logic [1:0] exp_an(input int c);
    return ((c / 4) % 2 == 1) ? 2'b01 : 2'b10;
  endfunction

  initial begin
    bus0.EI       = 1'b1;
    bus0.HOLD     = 1'b0;
    bus0.DataIn   = '0;
    bus_up.EI     = 1'b1;
    bus_up.HOLD   = 1'b0;
    bus_up.DataIn = '0;
    bus_lo.HOLD   = 1'b0;
    bus_lo.DataIn = '0;

    // Reset state, held three cycles
    repeat (3) tick();
    check("rst_y",   bus0.Y,   0);
    check("rst_gs",  bus0.GS,  0);
    check("rst_eo",  bus0.EO,  1);
    check("rst_an",  bus0.An,  2'b10);
    check("rst_seg", bus0.Seg, 8'hFF);

    // Disabled, no hold: dashes on both digits
    rst = 1'b0;
    tick();
    check("first_seg", bus0.Seg, 8'hBF);
    goto_phase(0);
    check("dash0_an",  bus0.An,  2'b10);
    check("dash0_seg", bus0.Seg, 8'hBF);
    goto_phase(4);
    check("dash1_an",  bus0.An,  2'b01);
    check("dash1_seg", bus0.Seg, 8'hBF);
    check("dis_gs",    bus0.GS,  0);
    check("dis_eo",    bus0.EO,  1);

    // Priority
    bus0.EI = 1'b0;
    bus0.DataIn = 16'h0081;
    tick();
    check("p81_y",  bus0.Y,  7);
    check("p81_gs", bus0.GS, 1);
    check("p81_eo", bus0.EO, 1);
    bus0.DataIn = 16'h8001;
    tick();
    check("p8001_y", bus0.Y, 15);
    bus0.DataIn = 16'h0001;
    tick();
    check("p1_y",  bus0.Y,  0);
    check("p1_gs", bus0.GS, 1);
    goto_phase(0);
    check("zero_d0", bus0.Seg, 8'hC0);
    goto_phase(4);
    check("zero_d1", bus0.Seg, 8'hFF);
    bus0.DataIn = 16'h0000;
    tick();
    check("none_gs", bus0.GS, 0);
    check("none_eo", bus0.EO, 0);
    check("none_y",  bus0.Y,  0);

    // Hold mode
    bus0.DataIn = 16'h0400;
    tick();
    check("h_load_y", bus0.Y, 10);
    bus0.HOLD = 1'b1;
    bus0.DataIn = 16'h0000;
    tick();
    check("hold_y",  bus0.Y,  10);
    check("hold_gs", bus0.GS, 0);
    goto_phase(0);
    check("hold_d0", bus0.Seg, 8'hC0);
    goto_phase(4);
    check("hold_d1", bus0.Seg, 8'hF9);
    bus0.HOLD = 1'b0;
    tick();
    check("nohold_y", bus0.Y, 0);
    goto_phase(0);
    check("nohold_d0", bus0.Seg, 8'hBF);
    goto_phase(4);
    check("nohold_d1", bus0.Seg, 8'hBF);

    // Scan: Y=13, each digit lit exactly 4 cycles
    bus0.DataIn = 16'h2000;
    goto_phase(0);
    check("y13",        bus0.Y,   13);
    check("scan_an0",   bus0.An,  2'b10);
    check("scan_seg3",  bus0.Seg, 8'hB0);
    repeat (3) tick();
    check("scan_an0_h", bus0.An,  2'b10);
    tick();
    check("scan_an1",   bus0.An,  2'b01);
    check("scan_seg1",  bus0.Seg, 8'hF9);
    repeat (3) tick();
    check("scan_an1_h", bus0.An,  2'b01);
    tick();
    check("scan_an0_w", bus0.An,  2'b10);

    // Y=5: upper digit blanked
    bus0.DataIn = 16'h0020;
    goto_phase(4);
    check("y5_d1", bus0.Seg, 8'hFF);
    goto_phase(0);
    check("y5_d0", bus0.Seg, 8'h92);

    // EI deasserted mid-scan: encode updates, scan keeps going
    goto_phase(2);
    bus0.EI = 1'b1;
    tick();
    check("ei_gs",   bus0.GS, 0);
    check("ei_eo",   bus0.EO, 1);
    check("ei_scan", bus0.An, exp_an(cyc));

    // Reset mid-frame restarts the scan at digit 0, div 0
    goto_phase(5);
    rst = 1'b1;
    tick();
    check("mrst_an",  bus0.An,  2'b10);
    check("mrst_seg", bus0.Seg, 8'hFF);
    rst = 1'b0;
    repeat (3) tick();
    check("mrst_an_h", bus0.An, 2'b10);
    tick();
    check("mrst_an_1", bus0.An, 2'b01);

    // Cascade: upper disabled -> lower disabled
    bus_up.EI = 1'b1;
    bus_up.DataIn = 8'h10;
    bus_lo.DataIn = 8'h08;
    tick();
    check("up_dis_gs", bus_up.GS, 0);
    check("up_dis_eo", bus_up.EO, 1);
    tick();
    check("lo_dis_gs", bus_lo.GS, 0);
    check("lo_dis_eo", bus_lo.EO, 1);

    // Upper idle -> lower enabled one cycle later
    bus_up.EI = 1'b0;
    bus_up.DataIn = 8'h00;
    tick();
    check("up_idle_eo", bus_up.EO, 0);
    check("up_idle_gs", bus_up.GS, 0);
    check("lo_skew_gs", bus_lo.GS, 0);
    tick();
    check("lo_en_y",  bus_lo.Y,  3);
    check("lo_en_gs", bus_lo.GS, 1);

    // Upper request returns: lower keeps its code one more cycle
    bus_up.DataIn = 8'h40;
    tick();
    check("up_req_y",  bus_up.Y,  6);
    check("up_req_eo", bus_up.EO, 1);
    check("lo_lag_gs", bus_lo.GS, 1);
    tick();
    check("lo_off_gs", bus_lo.GS, 0);
    check("lo_off_eo", bus_lo.EO, 1);
    check("lo_off_y",  bus_lo.Y,  0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/prio_enc_seg_scan.md
# prio_enc_seg_scan

Parametrised, registered priority encoder with cascade enable and a multiplexed seven-segment display driver. Successor to the fixed 16-line encoder/display block: request width, digit count, scan rate and segment polarity are generics, and it adds a registered output stage, an optional hold mode and time-multiplexed digit scanning. Sits between raw request lines (switches/IRQ-style inputs) and the board's seven-segment display. Its registered code is also available to other logic.

## Interface
Parameters:
- IN_WIDTH, 16: number of request lines; legal range 2..256.
- CODE_W, 4: width of Y; must equal ceil(log2(IN_WIDTH)).
- DIGITS, 2: number of decimal digits driven; must be enough for IN_WIDTH-1.
- SCAN_DIV, 1000: SYSCLK cycles each digit is lit; must be at least 2.
- SEG_ACTIVE_LOW, 1: 1 means Seg and An are active-low; 0 means active-high.

Ports:
- SYSCLK  in  1  system clock; all logic rises on the posedge.
- SYSRESET  in  1  synchronous, active-high reset.
- EI  in  1  cascade enable, active-low; 0 enables the encoder.
- HOLD  in  1  1 keeps the last valid Y when no request is present.
- DataIn  in  IN_WIDTH  request lines, active-high; the highest index has priority.
- Y  out  CODE_W  registered index of the highest active request.
- GS  out  1  registered "group select": enabled and at least one request active.
- EO  out  1  registered cascade output, active-low; 0 when enabled and no request. Drives the next stage's EI.
- Seg  out  8  segment drive {dp,g,f,e,d,c,b,a}; dp is always off.
- An  out  DIGITS  one-hot digit select; bit 0 is the least-significant digit.

## Operation
- Encode stage, evaluated every cycle:
  - en = ~EI; any = |DataIn; idx = index of the highest set bit of DataIn.
  - en & any: Y<=idx, GS<=1, EO<=1.
  - en & ~any: GS<=0, EO<=0.
  - ~en: GS<=0, EO<=1.
  - Y in the no-GS cases: keeps its value if HOLD=1, otherwise loads 0.
- Display value:
  - When GS=1 or HOLD=1, Y is converted to DIGITS BCD digits.
  - Leading zeros are blanked; the least-significant digit is always shown, so 0 displays as "0".
  - When GS=0 and HOLD=0, every digit shows "-" (segment g only).
- Glyphs 0-9 use standard a-g patterns. Polarity is applied last: all Seg/An bits are inverted when SEG_ACTIVE_LOW=1.
- Scan:
  - div counter runs 0..SCAN_DIV-1.
  - At the terminal count, div wraps to 0 and digit index dsel advances 0..DIGITS-1, wrapping to 0.
  - An asserts bit dsel only.
  - Seg is registered from the glyph of digit dsel of the current display value.
- Y/GS/EO do not depend on the scan state.

## Timing
- Reset, while SYSRESET=1 at a posedge:
  - Y=0, GS=0, EO=1.
  - div=0, dsel=0.
  - An = digit 0 active; Seg = all segments off (polarity applied).
- First lit glyph appears one cycle after reset release.
- Encode latency is 1 cycle: DataIn/EI/HOLD sampled at edge k appear on Y/GS/EO after edge k.
- Display latency is 1 cycle after Y/GS (Seg is registered). A Y change reaches the lit digit by the next edge; other digits update when scanned.
- An and Seg change on the same edge. Each digit is lit for exactly SCAN_DIV cycles, so the full frame is DIGITS*SCAN_DIV cycles.
- Boundary conditions:
  - All DataIn bits set: Y = IN_WIDTH-1.
  - Only DataIn[0] set: Y=0 with GS=1. This is distinct from the no-request case by GS.
  - EI deasserting mid-scan: encode outputs update next cycle; the scan counters are unaffected.
  - SYSRESET mid-frame: restarts the scan at digit 0, div=0.
  - Cascading two instances, upper stage EO -> lower stage EI: the lower stage sees the upper stage's state with one extra cycle of latency. Users combine GS with that one-cycle skew in mind.

## Test plan
- Reset and polarity, SEG_ACTIVE_LOW=1: hold SYSRESET 3 cycles.
  - Expect Y=0, GS=0, EO=1, An=2'b10, Seg=8'hFF.
  - After release with EI=1, HOLD=0: Seg=8'hBF ("-") on every digit.
- Priority, IN_WIDTH=16, EI=0:
  - DataIn=16'h0081 -> Y=7, GS=1 one cycle later.
  - DataIn=16'h8001 -> Y=15.
  - DataIn=16'h0001 -> Y=0 with GS=1.
  - DataIn=0 -> GS=0, EO=0.
- Hold mode: DataIn=16'h0400 (Y=10), then DataIn=0.
  - HOLD=1: Y stays 10 and the display shows "10".
  - HOLD=0: Y=0 and the display shows "--".
- Scan, SCAN_DIV=4, DIGITS=2, Y=13:
  - An alternates every 4 cycles.
  - Digit 0 Seg = active-low "3" (8'hB0); digit 1 Seg = "1" (8'hF9).
  - Y=5: digit 1 is blank (8'hFF).
- Enable and cascade, two 8-line instances:
  - EI=1 on the upper stage -> upper GS=0, EO=1; lower stage disabled.
  - Upper stage idle -> upper EO=0 enables the lower stage; the lower stage's DataIn[3] gives lower Y=3 one cycle later.
  - SYSRESET pulse mid-frame -> dsel=0, div=0 on the next edge.
